// File: rtl/nes_pio_pkg.sv
// nes_pio_pkg: definitions shared by the nes_gpio_pio slice.
//   - Avalon register addresses for the PIO register map.
//   - EDGE_TYPE encodings that select which input transition sets EDGECAP.
package nes_pio_pkg;

    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_DIR     = 3'd1;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nes_gpio_pio_if.sv
// nes_gpio_pio_if: Avalon-MM slave bus of the PIO.
//   address    [2:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] combinational read data (zero wait states)
// Modports: master (Nios side / bench), slave (PIO).
interface nes_gpio_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nes_pio_sync.sv
// nes_pio_sync: WIDTH-wide two-flop synchroniser plus a one-cycle delayed
// copy ("prev") used for edge detection.
//   clk, reset_n        system clock, asynchronous active-low reset
//   in_async [WIDTH]    raw pin inputs
//   sync     [WIDTH]    synchronised inputs (second flop)
//   rise     [WIDTH]    sync & ~prev
//   fall     [WIDTH]    ~sync & prev
module nes_pio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
            prev_reg <= '0;
        end else begin
            meta_reg <= in_async;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign sync = sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign rise[gi] =  sync_reg[gi] & ~prev_reg[gi];
            assign fall[gi] = ~sync_reg[gi] &  prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/nes_gpio_pio.sv
// nes_gpio_pio: parametrised Avalon-MM general-purpose I/O port.
//   clk, reset_n   system clock, asynchronous active-low reset
//   avs            Avalon slave bus (nes_gpio_pio_if.slave)
//   in_port        asynchronous pin inputs      [WIDTH]
//   out_port       output data register         [WIDTH]
//   out_en         direction register, 1=drive  [WIDTH]
//   irq            level interrupt |(EDGECAP & IRQMASK)
// Registers: DATA, DIR, IRQMASK, EDGECAP (W1C), OUTSET, OUTCLR.
// Build option: define NES_PIO_IRQ_EN to build IRQMASK and the irq logic;
// otherwise IRQMASK reads 0, ignores writes and irq is tied low.
module nes_gpio_pio
    import nes_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    nes_gpio_pio_if.slave    avs,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("nes_gpio_pio: WIDTH must be in 1..32");
    end

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_rise;
    logic [WIDTH-1:0] in_fall;
    logic [31:0]      rd_data;
    // Bits of writedata above WIDTH are intentionally ignored.
    logic             unused_wd;

    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign wd        = avs.writedata[WIDTH-1:0];
    assign unused_wd = ^avs.writedata;

    nes_pio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_async (in_port),
        .sync     (in_sync),
        .rise     (in_rise),
        .fall     (in_fall)
    );

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = in_rise;
            EDGE_FALL: edge_hit = in_fall;
            default:   edge_hit = in_rise | in_fall;
        endcase
    end

    // W1C clear mask; a new edge in the same cycle is OR-ed in afterwards
    // so that a set always beats a clear.
    assign cap_clr = (wr_en && avs.address == PIO_EDGECAP) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= RESET_VALUE;
            dir_reg <= DIR_RESET;
            cap_reg <= '0;
        end else begin
            if (wr_en) begin
                case (avs.address)
                    PIO_DATA:   out_reg <= wd;
                    PIO_OUTSET: out_reg <= out_reg | wd;
                    PIO_OUTCLR: out_reg <= out_reg & ~wd;
                    PIO_DIR:    dir_reg <= wd;
                    default:    ;
                endcase
            end
            cap_reg <= (cap_reg & ~cap_clr) | edge_hit;
        end
    end

`ifdef NES_PIO_IRQ_EN
    logic [WIDTH-1:0] mask_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg <= '0;
        end else if (wr_en && avs.address == PIO_IRQMASK) begin
            mask_reg <= wd;
        end
    end

    assign irq = |(cap_reg & mask_reg);
`else
    assign irq = 1'b0;
`endif

    // Read mux: pure function of address and register state.
    always_comb begin
        rd_data = '0;
        case (avs.address)
            PIO_DATA:    rd_data[WIDTH-1:0] = (out_reg & dir_reg) | (in_sync & ~dir_reg);
            PIO_DIR:     rd_data[WIDTH-1:0] = dir_reg;
`ifdef NES_PIO_IRQ_EN
            PIO_IRQMASK: rd_data[WIDTH-1:0] = mask_reg;
`endif
            PIO_EDGECAP: rd_data[WIDTH-1:0] = cap_reg;
            default:     rd_data = '0;
        endcase
    end

    assign avs.readdata = rd_data;
    assign out_port     = out_reg;
    assign out_en       = dir_reg;

endmodule
